pa_frame_codec: RTL

PA_FRAME_CODEC -- requirements
Module: pa_frame_codec

---
 rtl/pa_frame_pkg.sv | 53 +++++
 rtl/pa_frame_rx.sv | 116 +++++++++++
 rtl/pa_frame_codec.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pa_frame_pkg.sv
// Shared definitions for the PA serial frame codec: header defaults,
// frame lengths, FSM encodings and checksum helpers.
package pa_frame_pkg;

  localparam logic [7:0] TX_HDR_DEF = 8'hA5;
  localparam logic [7:0] RX_HDR_DEF = 8'h5A;

  localparam int unsigned CSUM_W         = 8;
  localparam int unsigned TX_FRAME_LEN   = 6;
  localparam int unsigned RX_FRAME_LEN   = 7;
  localparam int unsigned RX_PAYLOAD_LEN = RX_FRAME_LEN - 2;

  localparam logic [2:0] TX_LAST_IDX     = 3'(TX_FRAME_LEN - 1);
  localparam logic [2:0] RX_LAST_PAYLOAD = 3'(RX_PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    TX_IDLE     = 3'd0,
    TX_LOAD     = 3'd1,
    TX_WAIT_TX  = 3'd2,
    TX_STROBE   = 3'd3,
    TX_WAIT_RSP = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HUNT    = 2'd0,
    RX_PAYLOAD = 2'd1,
    RX_CHECK   = 2'd2
  } rx_state_e;

  // Running modulo-256 checksum accumulation.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + b;
  endfunction

  // Byte idx (0..5) of the outgoing frame for command word d.
  function automatic logic [7:0] tx_frame_byte(input logic [7:0]  hdr,
                                               input logic [31:0] d,
                                               input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = d[31:24];
      3'd2:    b = d[23:16];
      3'd3:    b = d[15:8];
      3'd4:    b = d[7:0];
      3'd5:    b = csum_add(csum_add(csum_add(d[31:24], d[23:16]), d[15:8]), d[7:0]);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pa_frame_rx.sv
// RX frame parser: hunts for the header, shifts in five payload bytes,
// checks the trailing checksum and aborts frames that stall too long.
module pa_frame_rx
  import pa_frame_pkg::*;
#(
  parameter logic [7:0]  RX_HDR      = RX_HDR_DEF,
  parameter logic [15:0] GAP_TIMEOUT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_byte_vld_i,
  input  logic [7:0]  rx_byte_i,
  output logic        frame_good_o,
  output logic [39:0] frame_data_o
);

  rx_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [39:0]       shift_q, shift_d;
  logic [15:0]       gap_q, gap_d;
  logic              gap_expire_s;

  // Abort after GAP_TIMEOUT consecutive idle cycles inside a frame.
  assign gap_expire_s = (gap_q == (GAP_TIMEOUT - 16'd1)) && !rx_byte_vld_i;
  assign frame_data_o = shift_q;

  // Parser state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Parser next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_HUNT: begin
        if (rx_byte_vld_i && (rx_byte_i == RX_HDR)) state_d = RX_PAYLOAD;
        else                                         state_d = RX_HUNT;
      end
      RX_PAYLOAD: begin
        if (rx_byte_vld_i) begin
          if (cnt_q == RX_LAST_PAYLOAD) state_d = RX_CHECK;
          else                          state_d = RX_PAYLOAD;
        end else if (gap_expire_s) begin
          state_d = RX_HUNT;
        end else begin
          state_d = RX_PAYLOAD;
        end
      end
      RX_CHECK: begin
        if (rx_byte_vld_i || gap_expire_s) state_d = RX_HUNT;
        else                               state_d = RX_CHECK;
      end
      default: state_d = RX_HUNT;
    endcase
  end

  // Payload shift, checksum accumulation, gap timer and good-frame decode.
  always_comb begin
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    shift_d      = shift_q;
    gap_d        = gap_q;
    frame_good_o = 1'b0;
    case (state_q)
      RX_HUNT: begin
        cnt_d = 3'd0;
        sum_d = {CSUM_W{1'b0}};
        gap_d = 16'd0;
      end
      RX_PAYLOAD: begin
        if (rx_byte_vld_i) begin
          shift_d = {shift_q[31:0], rx_byte_i};
          sum_d   = csum_add(sum_q, rx_byte_i);
          cnt_d   = cnt_q + 3'd1;
          gap_d   = 16'd0;
        end else begin
          gap_d   = gap_q + 16'd1;
        end
      end
      RX_CHECK: begin
        if (rx_byte_vld_i) begin
          frame_good_o = (rx_byte_i == sum_q);
          gap_d        = 16'd0;
        end else begin
          gap_d        = gap_q + 16'd1;
        end
      end
      default: begin
        cnt_d = 3'd0;
        gap_d = 16'd0;
      end
    endcase
  end

  // Parser datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      sum_q   <= {CSUM_W{1'b0}};
      shift_q <= 40'd0;
      gap_q   <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      shift_q <= shift_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: rtl/pa_frame_codec.sv
// PA command/response codec: frames 32-bit commands onto a byte UART,
// waits for the PA response and publishes good response payloads.
module pa_frame_codec
  import pa_frame_pkg::*;
#(
  parameter logic [7:0]  TX_HDR      = TX_HDR_DEF,
  parameter logic [7:0]  RX_HDR      = RX_HDR_DEF,
  parameter logic [31:0] RSP_TIMEOUT = 32'd2_500_000,
  parameter logic [15:0] GAP_TIMEOUT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_en,
  input  logic [31:0] send_data,
  output logic        tx_byte_vld,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  input  logic        rx_byte_vld,
  input  logic [7:0]  rx_byte,
  output logic [39:0] recieve_data,
  output logic        recirve_vld,
  output logic        rsp_timeout,
  output logic        cmd_drop,
  output logic        busy
);

  tx_state_e   state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        hold_q, hold_d;
  logic [31:0] rsp_cnt_q, rsp_cnt_d;

  logic        tx_byte_vld_q, tx_byte_vld_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [39:0] recieve_data_q, recieve_data_d;
  logic        recirve_vld_q, recirve_vld_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        cmd_drop_q, cmd_drop_d;
  logic        busy_q, busy_d;

  logic        accept_s;
  logic        rsp_end_s;
  logic        timeout_s;
  logic        frame_good_s;
  logic [39:0] frame_data_s;

  pa_frame_rx #(
    .RX_HDR      (RX_HDR),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_byte_vld_i (rx_byte_vld),
    .rx_byte_i     (rx_byte),
    .frame_good_o  (frame_good_s),
    .frame_data_o  (frame_data_s)
  );

  assign tx_byte_vld  = tx_byte_vld_q;
  assign tx_byte      = tx_byte_q;
  assign recieve_data = recieve_data_q;
  assign recirve_vld  = recirve_vld_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign cmd_drop     = cmd_drop_q;
  assign busy         = busy_q;

  // TX state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // TX next-state logic; a good frame beats a timeout in the same cycle,
  // and a command arriving as the response wait ends is taken directly.
  always_comb begin
    state_d   = state_q;
    accept_s  = 1'b0;
    rsp_end_s = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (send_en) begin
          state_d  = TX_LOAD;
          accept_s = 1'b1;
        end else begin
          state_d  = TX_IDLE;
        end
      end
      TX_LOAD: state_d = TX_WAIT_TX;
      TX_WAIT_TX: begin
        if (!tx_busy) state_d = TX_STROBE;
        else          state_d = TX_WAIT_TX;
      end
      TX_STROBE: begin
        // First STROBE cycle drives the strobe; the second gives tx_busy time to rise.
        if (!hold_q)                   state_d = TX_STROBE;
        else if (idx_q == TX_LAST_IDX) state_d = TX_WAIT_RSP;
        else                           state_d = TX_WAIT_TX;
      end
      TX_WAIT_RSP: begin
        if (frame_good_s) begin
          rsp_end_s = 1'b1;
        end else if (rsp_cnt_q == (RSP_TIMEOUT - 32'd1)) begin
          rsp_end_s = 1'b1;
          timeout_s = 1'b1;
        end else begin
          rsp_end_s = 1'b0;
        end
        if (!rsp_end_s) begin
          state_d  = TX_WAIT_RSP;
        end else if (send_en) begin
          state_d  = TX_LOAD;
          accept_s = 1'b1;
        end else begin
          state_d  = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // TX datapath and output register next values. The response counter is
  // zeroed when each byte strobe is launched and keeps counting from the
  // last byte's strobe, so the timeout lands RSP_TIMEOUT cycles after it.
  always_comb begin
    data_d        = data_q;
    idx_d         = idx_q;
    hold_d        = 1'b0;
    rsp_cnt_d     = rsp_cnt_q;
    tx_byte_vld_d = 1'b0;
    tx_byte_d     = tx_byte_q;
    recirve_vld_d = frame_good_s;
    rsp_timeout_d = timeout_s;
    cmd_drop_d    = send_en && !accept_s;
    busy_d        = (state_d != TX_IDLE);
    if (frame_good_s) recieve_data_d = frame_data_s;
    else              recieve_data_d = recieve_data_q;
    case (state_q)
      TX_WAIT_TX: begin
        if (!tx_busy) begin
          tx_byte_vld_d = 1'b1;
          tx_byte_d     = tx_frame_byte(TX_HDR, data_q, idx_q);
          rsp_cnt_d     = 32'd0;
        end else begin
          tx_byte_vld_d = 1'b0;
        end
      end
      TX_STROBE: begin
        hold_d = !hold_q;
        if (idx_q == TX_LAST_IDX) rsp_cnt_d = rsp_cnt_q + 32'd1;
        else                      rsp_cnt_d = rsp_cnt_q;
        if (!hold_q)                   idx_d = idx_q;
        else if (idx_q == TX_LAST_IDX) idx_d = 3'd0;
        else                           idx_d = idx_q + 3'd1;
      end
      TX_WAIT_RSP: rsp_cnt_d = rsp_cnt_q + 32'd1;
      default:     hold_d    = 1'b0;
    endcase
    if (accept_s) begin
      data_d    = send_data;
      idx_d     = 3'd0;
      rsp_cnt_d = 32'd0;
    end else begin
      data_d    = data_q;
    end
  end

  // TX datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q         <= 32'd0;
      idx_q          <= 3'd0;
      hold_q         <= 1'b0;
      rsp_cnt_q      <= 32'd0;
      tx_byte_vld_q  <= 1'b0;
      tx_byte_q      <= 8'd0;
      recieve_data_q <= 40'd0;
      recirve_vld_q  <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      cmd_drop_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      data_q         <= data_d;
      idx_q          <= idx_d;
      hold_q         <= hold_d;
      rsp_cnt_q      <= rsp_cnt_d;
      tx_byte_vld_q  <= tx_byte_vld_d;
      tx_byte_q      <= tx_byte_d;
      recieve_data_q <= recieve_data_d;
      recirve_vld_q  <= recirve_vld_d;
      rsp_timeout_q  <= rsp_timeout_d;
      cmd_drop_q     <= cmd_drop_d;
      busy_q         <= busy_d;
    end
  end

endmodule
